des_expand_mix_pipe: RTL and testbench



---
 rtl/des_expand_mix_pipe.sv | 111 +++++++++++
 tb/tb_des_expand_mix_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_expand_mix_pipe.sv
// Multi-lane DES E-expansion and round-key mix, pipelined over DEPTH register
// stages with a valid/ready stream and full backpressure.
module des_expand_mix_pipe #(
  parameter int LANES = 1,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_r,
  input  logic [48*LANES-1:0]   in_k,
  input  logic                  in_mix,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [48*LANES-1:0]   out_e,
  output logic [TAG_W-1:0]      out_tag,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam int DW = 48 * LANES;

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][DW-1:0]     dat_q, dat_d;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0]             ld;
  logic [DW-1:0]                stage_in;

  // Each 6-bit E group b takes DES bits 4b..4b+5 (1-indexed, wrapping 0->32, 33->1).
  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [47:0] e;
    int unsigned n;
    e = '0;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 6; k++) begin
        n = (4 * b + k + 31) % 32;
        e[47-(6*b+k)] = r[31-n];
      end
    end
    return e;
  endfunction

  always_comb begin
    stage_in = '0;
    for (int i = 0; i < LANES; i++) begin
      stage_in[48*i +: 48] = e_expand(in_r[32*i +: 32]) ^ (in_mix ? in_k[48*i +: 48] : 48'd0);
    end
  end

  // Load enables ripple from the output back to stage 0.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    ld  = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      ld[j] = !vld_q[j] || nxt;
      nxt   = ld[j];
    end
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    if (ld[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        dat_d[0] = stage_in;
        tag_d[0] = in_tag;
      end
    end
    for (int j = 1; j < DEPTH; j++) begin
      if (ld[j]) begin
        vld_d[j] = vld_q[j-1];
        if (vld_q[j-1]) begin
          dat_d[j] = dat_q[j-1];
          tag_d[j] = tag_q[j-1];
        end
      end
    end
    if (in_valid && ld[0]) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[DEPTH-1];
  assign out_e     = dat_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_des_expand_mix_pipe.sv
// Scoreboard bench for des_expand_mix_pipe: driver pushes expected results on
// each accepted transfer, a negedge monitor pops and compares on each emit.
module tb_des_expand_mix_pipe;

  localparam int LANES = 2;
  localparam int DEPTH = 3;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_r;
  logic [95:0]       in_k;
  logic              in_mix;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [95:0]       out_e;
  logic [TAG_W-1:0]  out_tag;
  logic [CNT_W-1:0]  xfer_cnt;

  des_expand_mix_pipe #(.LANES(LANES), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_k(in_k), .in_mix(in_mix), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_e(out_e),
    .out_tag(out_tag), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0]      e;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               lat;
  } exp_t;

  exp_t             sb[$];
  int               nchk = 0;
  int               nerr = 0;
  int               cyc  = 0;
  int               mode = 0;
  logic [95:0]      exp_cur;
  bit               lat_cur;

  int etab[48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                    8, 9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,
                   24,25,26,27,28,29,28,29,30,31,32, 1};

  function automatic logic [47:0] m_lane(input logic [31:0] r, input logic [47:0] k, input logic mix);
    logic [47:0] e;
    for (int m = 1; m <= 48; m++) e[48-m] = r[32-etab[m-1]];
    return e ^ (mix ? k : 48'd0);
  endfunction

  function automatic logic [95:0] m_all(input logic [63:0] r, input logic [95:0] k, input logic mix);
    return {m_lane(r[63:32], k[95:48], mix), m_lane(r[31:0], k[47:0], mix)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: queue size at the start of each negedge equals pipeline occupancy.
  logic             prev_stall = 1'b0;
  logic [95:0]      prev_e;
  logic [TAG_W-1:0] prev_tag;
  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 128'(in_ready), 128'(!(sb.size() == DEPTH && !out_ready)));
      if (prev_stall) begin
        chk("stall_valid", 128'(out_valid), 128'(1));
        chk("stall_e", 128'(out_e), 128'(prev_e));
        chk("stall_tag", 128'(out_tag), 128'(prev_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 128'(out_tag), 128'(0));
          if (out_tag == 0) begin
            nerr++;
            $display("FAIL unexpected_output: got e=%0h with no transfer pending", out_e);
          end
        end else begin
          x = sb.pop_front();
          chk("out_e", 128'(out_e), 128'(x.e));
          chk("out_tag", 128'(out_tag), 128'(x.tag));
          if (x.lat) chk("latency", 128'(cyc - x.cyc), 128'(DEPTH));
        end
      end
      if (in_valid && in_ready) begin
        x.e = exp_cur; x.tag = in_tag; x.cyc = cyc; x.lat = lat_cur;
        sb.push_back(x);
      end
      prev_stall = out_valid && !out_ready;
      prev_e     = out_e;
      prev_tag   = out_tag;
    end
  end

  task automatic send(input logic [63:0] r, input logic [95:0] k, input logic mix,
                      input logic [TAG_W-1:0] tag, input logic [95:0] e, input bit lat);
    bit got;
    int n = 0;
    in_r = r; in_k = k; in_mix = mix; in_tag = tag; exp_cur = e; lat_cur = lat;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      got = in_ready && !rst;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 200);
    if (!got) chk("send_timeout", 128'(0), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_k = '0; in_mix = 1'b0; in_tag = '0;
    exp_cur = '0; lat_cur = 1'b0;
    cycles(2);
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_e", 128'(out_e), 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));
    chk("rst_xfer_cnt", 128'(xfer_cnt), 128'(0));

    // Directed vectors, hand-computed results, isolated so latency is checked.
    mode = 0;
    send({32'h0, 32'h00000001}, 96'h0, 1'b1, 4'h5, {48'h0, 48'h800000000002}, 1'b1);
    drain();
    send({32'h0, 32'h80000000}, {48'hFFFFFFFFFFFF, 48'h0}, 1'b1, 4'h6,
         {48'hFFFFFFFFFFFF, 48'h400000000001}, 1'b1);
    drain();
    send({2{32'hFFFFFFFF}}, {2{48'hFFFFFFFFFFFF}}, 1'b0, 4'h7, {2{48'hFFFFFFFFFFFF}}, 1'b1);
    send({2{32'hFFFFFFFF}}, {2{48'hFFFFFFFFFFFF}}, 1'b1, 4'h8, 96'h0, 1'b0);
    send(64'h0, {48'h0, 48'h123456789ABC}, 1'b0, 4'h9, 96'h0, 1'b0);
    drain();
    chk("xfer_cnt_directed", 128'(xfer_cnt), 128'(5));

    // Random backpressure stream, tags 0..9.
    pulse_reset();
    mode = 1;
    for (int t = 0; t < 10; t++) begin
      logic [63:0] r;
      logic [95:0] k;
      r = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom};
      send(r, k, 1'(t % 3 != 0), 4'(t), m_all(r, k, 1'(t % 3 != 0)), 1'b0);
    end
    mode = 0;
    drain();
    chk("xfer_cnt_stream", 128'(xfer_cnt), 128'(10));

    // Fill the pipe under stall, then reset mid-stream.
    mode = 2;
    cycles(2);
    for (int t = 0; t < DEPTH; t++) send({2{32'(t + 1)}}, 96'h0, 1'b0, 4'(t + 10), 96'h0, 1'b0);
    chk("full_in_ready", 128'(in_ready), 128'(0));
    pulse_reset();
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_xfer_cnt", 128'(xfer_cnt), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    mode = 1;
    cycles(20);
    chk("no_stale", 128'(sb.size()), 128'(0));

    // Counter wrap at 2^CNT_W.
    mode = 0;
    for (int t = 0; t < 15; t++) send(64'h0, 96'h0, 1'b0, 4'(t), 96'h0, 1'b0);
    chk("cnt_15", 128'(xfer_cnt), 128'(15));
    send(64'h0, 96'h0, 1'b0, 4'hF, 96'h0, 1'b0);
    chk("cnt_16", 128'(xfer_cnt), 128'(0));
    send(64'h0, 96'h0, 1'b0, 4'h1, 96'h0, 1'b0);
    chk("cnt_17", 128'(xfer_cnt), 128'(1));
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
